// File: rtl/eth_10g_mac_st_timing_adapter_fifo_pkg.sv
// Shared helpers for the 10G MAC side-band adapters: pointer/level widths
// and the saturating increment used by the MAC statistics counters.
package eth_10g_st_adapter_pkg;

    // Pointer width: one extra MSB beyond the address separates full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Occupancy width able to represent 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Increment that sticks at all-ones for a counter of the given width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/eth_10g_mac_st_timing_adapter_fifo_if.sv
// Avalon-ST handshake bundle: ready-less upstream beat plus downstream
// valid/data/ready.
interface eth_10g_mac_st_timing_adapter_fifo_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Environment side: drives the upstream beat and the downstream ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    // Adapter side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/eth_10g_mac_st_timing_adapter_fifo_sync_fifo.sv
// Single-clock FIFO: register-array storage, wrap-bit pointers and a
// registered occupancy count.
module eth_10g_st_sync_fifo
    import eth_10g_st_adapter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int AW    = PTR_W - 1;
    localparam int LVL_W = lvl_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_data    = mem[rd_ptr[AW-1:0]];
    assign fill_level = level;

    // Payload storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance and occupancy tracking; push+pop leaves the level unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/eth_10g_mac_st_timing_adapter_fifo.sv
// Timing adapter between a ready-less source and a backpressuring sink.
// Beats are buffered; a beat arriving while full with no pop is dropped
// and recorded in a sticky flag and a saturating counter.
module eth_10g_mac_st_timing_adapter_fifo
    import eth_10g_st_adapter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    eth_10g_mac_st_timing_adapter_fifo_if.slave st,
    input  logic                                clear_stats,
    output logic                                overflow,
    output logic [CNT_W-1:0]                    drop_count,
    output logic [$clog2(DEPTH+1)-1:0]          fill_level
);
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;

    // A pop frees the head slot in the same cycle, so a full FIFO still
    // accepts an incoming beat when the sink is taking one.
    assign pop          = st.out_valid & st.out_ready;
    assign push         = st.in_valid & (~full | pop);
    assign drop         = st.in_valid & full & ~pop;
    assign st.out_valid = ~empty;

    eth_10g_st_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .wr_data    (st.in_data),
        .rd_data    (st.out_data),
        .full       (full),
        .empty      (empty),
        .fill_level (fill_level)
    );

    // Drop statistics; a drop coinciding with clear_stats is kept as the first new count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_stats) begin
            overflow   <= drop;
            drop_count <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= CNT_W'(sat_inc(32'(drop_count), CNT_W));
        end
    end
endmodule

// File: tb/tb_eth_10g_mac_st_timing_adapter_fifo.sv
// Directed bench for the side-band timing adapter (DATA_W=16, DEPTH=4, CNT_W=2).
module tb_eth_10g_mac_st_timing_adapter_fifo;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;

    logic                       clk;
    logic                       reset_n;
    logic                       clear_stats;
    logic                       overflow;
    logic [CNT_W-1:0]           drop_count;
    logic [$clog2(DEPTH+1)-1:0] fill_level;

    int vectors    = 0;
    int miscompares = 0;

    eth_10g_mac_st_timing_adapter_fifo_if #(.DATA_W(DATA_W)) sif ();

    eth_10g_mac_st_timing_adapter_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .st          (sif.slave),
        .clear_stats (clear_stats),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .fill_level  (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [15:0] d,
                             input int lvl, input logic ovf, input int dc);
        chk({tag, ".valid"}, 32'(sif.out_valid), 32'(v));
        if (v) chk({tag, ".data"}, 32'(sif.out_data), 32'(d));
        chk({tag, ".fill"}, 32'(fill_level), 32'(lvl));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
        chk({tag, ".drops"}, 32'(drop_count), 32'(dc));
    endtask

    initial begin
        reset_n       = 1'b0;
        clear_stats   = 1'b0;
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk_state("reset", 1'b0, 16'h0, 0, 1'b0, 0);
        reset_n = 1'b1;

        // Passthrough: 0x0001..0x0010 with 1-cycle latency, level stays 1
        sif.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            sif.in_valid = 1'b1;
            sif.in_data  = 16'(i);
            tick();
            chk_state($sformatf("pass%0d", i), 1'b1, 16'(i), 1, 1'b0, 0);
        end
        sif.in_valid = 1'b0;
        tick();
        chk_state("pass_drain", 1'b0, 16'h0, 0, 1'b0, 0);

        // Backpressure fill: head 0xA0 held stable while filling
        sif.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sif.in_valid = 1'b1;
            sif.in_data  = 16'hA0 + 16'(i);
            tick();
            chk_state($sformatf("fill%0d", i), 1'b1, 16'hA0, i + 1, 1'b0, 0);
        end

        // Overflow: three beats dropped, contents untouched
        for (int i = 0; i < 3; i++) begin
            sif.in_valid = 1'b1;
            sif.in_data  = 16'hC0 + 16'(i);
            tick();
            chk_state($sformatf("ovf%0d", i), 1'b1, 16'hA0, 4, 1'b1, i + 1);
        end

        // Full with simultaneous push and pop: 0xBB accepted at the tail
        sif.out_ready = 1'b1;
        sif.in_valid  = 1'b1;
        sif.in_data   = 16'hBB;
        tick();
        chk_state("fullpp", 1'b1, 16'hA1, 4, 1'b1, 3);
        sif.in_valid = 1'b0;
        tick();
        chk_state("drain_a2", 1'b1, 16'hA2, 3, 1'b1, 3);
        tick();
        chk_state("drain_a3", 1'b1, 16'hA3, 2, 1'b1, 3);
        tick();
        chk_state("drain_bb", 1'b1, 16'hBB, 1, 1'b1, 3);
        tick();
        chk_state("drain_empty", 1'b0, 16'h0, 0, 1'b1, 3);

        // clear_stats alone
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk_state("clear", 1'b0, 16'h0, 0, 1'b0, 0);

        // Saturation: fill, then five drops saturate a 2-bit counter at 3
        sif.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sif.in_valid = 1'b1;
            sif.in_data  = 16'h10 + 16'(i);
            tick();
        end
        chk_state("sat_full", 1'b1, 16'h10, 4, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            sif.in_data = 16'hE0 + 16'(i);
            tick();
            chk_state($sformatf("sat%0d", i), 1'b1, 16'h10, 4, 1'b1, (i < 3) ? i + 1 : 3);
        end

        // clear_stats together with a drop keeps that drop
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        sif.in_valid = 1'b0;
        chk_state("clear_drop", 1'b1, 16'h10, 4, 1'b1, 1);

        // Async reset between edges takes effect without a clock
        #3;
        reset_n = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 16'h0, 0, 1'b0, 0);
        tick();
        reset_n = 1'b1;

        // First beat after reset: not visible before the edge, visible after
        sif.in_valid = 1'b1;
        sif.in_data  = 16'h5555;
        #1;
        chk("no_comb_path", 32'(sif.out_valid), 32'(0));
        tick();
        sif.in_valid = 1'b0;
        chk_state("post_rst", 1'b1, 16'h5555, 1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/eth_10g_mac_st_timing_adapter_fifo.md
# eth_10g_mac_st_timing_adapter_fifo

Parametrised Avalon-ST timing adapter for the 10G MAC RX/TX side-band paths, such as pause length and statistics words. It connects an upstream source that has no ready signal to a downstream sink that can backpressure. Beats are absorbed in a DEPTH-entry FIFO instead of passing straight through. On overflow the incoming beat is dropped, and the drop is reported through sticky status and a saturating counter.

## Interface
- DATA_W, 16, payload width in bits (≥1)
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 8, drop counter width (≥1)
- clk  in  1  single clock; all logic is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream beat valid; no upstream ready exists
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  FIFO non-empty
- out_data  out  DATA_W  head-of-FIFO payload
- out_ready  in  1  downstream ready, ready latency 0
- clear_stats  in  1  synchronous clear of overflow and drop_count
- overflow  out  1  sticky flag: at least one beat dropped
- drop_count  out  CNT_W  dropped beats, saturating at 2^CNT_W−1
- fill_level  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- pop = out_valid & out_ready.
- push = in_valid & (fill_level < DEPTH | pop). When full, a simultaneous pop frees a slot, so the beat is accepted.
- drop = in_valid & (fill_level == DEPTH) & ~pop. The dropped beat is discarded and FIFO contents are unchanged.
- Storage: DEPTH × DATA_W register array.
- Pointers: write and read pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH. The MSB distinguishes full from empty.
- out_data = mem[rd_ptr[$clog2(DEPTH)-1:0]]. It is defined only when out_valid=1.
- out_data holds stable while out_valid=1 and out_ready=0, as Avalon-ST requires.
- fill_level is registered. It changes by +1 on push-only, by −1 on pop-only, and stays the same on push+pop.
- overflow is set on drop and cleared only by clear_stats or reset.
- drop_count increments on drop and holds at all-ones.
- clear_stats and drop in the same cycle: overflow=1 and drop_count=1 next cycle, so the drop is not lost.
- clear_stats alone: overflow=0 and drop_count=0 next cycle.
- Order is strictly FIFO. There is no reordering and no duplication.

## Timing
- Reset (reset_n=0, asynchronous): out_valid=0, fill_level=0, overflow=0, drop_count=0, pointers=0. Memory contents are don't-care.
- On reset deassertion, the first in_valid may arrive in the first cycle.
- Latency: a beat pushed at edge k is visible as out_valid=1 in the cycle after edge k. There is no combinational in→out path.
- Throughput: 1 beat/cycle sustained when out_ready=1 continuously. fill_level then stays at 1 in steady state.
- Empty with push: out_valid rises next cycle. A pop cannot occur in the same cycle because out_valid=0.
- Full, push and pop together: fill_level stays at DEPTH, the head advances and the new beat is stored at the tail.
- Reset mid-operation: FIFO contents are lost immediately and the outputs go to reset values asynchronously.
- All outputs are registered or driven directly by a register-addressed mux. There are no combinational paths from in_* to out_*.
- Simulation only: $display a warning on the first drop after reset or clear_stats.

## Structure
- Shared package eth_10g_st_adapter_pkg holds:
  - the ptr_w/lvl_w width functions;
  - the saturating-increment function, shared with other MAC statistics counters.
- One sub-module: eth_10g_st_sync_fifo, covering storage, pointers and fill_level with push/pop/full/empty.
- The top level adds the drop logic, the counters and clear_stats.

## Test plan
- Passthrough: DATA_W=16, DEPTH=4, out_ready=1. Stream 0x0001..0x0010 back-to-back → identical sequence out, 1-cycle latency, fill_level≤1, overflow=0.
- Backpressure fill: out_ready=0 while writing 0xA0..0xA3 → fill_level=4, out_data=0xA0 held stable. Release out_ready → 0xA0..0xA3 drained in order.
- Overflow: with the FIFO full and out_ready=0, write 3 more beats → all dropped, overflow=1, drop_count=3. The FIFO still contains 0xA0..0xA3.
- Full with simultaneous push and pop: FIFO full, out_ready=1, in_valid=1 with 0xBB → no drop, fill_level stays 4, 0xBB emerges 4th after the current head.
- Saturation and clear: CNT_W=2, force 5 drops → drop_count=3. Then assert clear_stats together with a drop → overflow=1, drop_count=1 next cycle.
- Async reset: assert reset_n=0 mid-stream between clock edges → out_valid, fill_level and flags go to 0 immediately. After release, a new beat 0x5555 appears with 1-cycle latency.
